// File: rtl/bus_handshake_synchronizer_pkg.sv
// Shared definitions for the bus handshake synchronizer.
//   SYNC_DEPTH_MIN / SYNC_DEPTH_MAX : legal flop-stage range per crossing
//   src_state_t                     : source-domain handshake FSM states
`timescale 1ns / 1ps
package bus_handshake_synchronizer_pkg;

  localparam int SYNC_DEPTH_MIN = 2;
  localparam int SYNC_DEPTH_MAX = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } src_state_t;

endpackage

// File: rtl/bus_handshake_synchronizer_if.sv
// Handshake/bus signal bundle for the bus handshake synchronizer.
//   in1_valid, in1_data, clear_overflow1 : source side, driven by the master
//   in1_ready, overflow1, count1         : source-domain status, driven by the slave
//   out2_valid, out2_data                : destination-domain delivery, driven by the slave
// The master modport belongs to whoever feeds words in; the slave modport
// belongs to the synchronizer itself.
`timescale 1ns / 1ps
interface bus_handshake_synchronizer_if #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
);
  import bus_handshake_synchronizer_pkg::*;

  logic                   in1_valid;
  logic [WIDTH-1:0]       in1_data;
  logic                   in1_ready;
  logic                   clear_overflow1;
  logic                   overflow1;
  logic [COUNT_WIDTH-1:0] count1;
  logic                   out2_valid;
  logic [WIDTH-1:0]       out2_data;

  modport master (
    output in1_valid, in1_data, clear_overflow1,
    input  in1_ready, overflow1, count1, out2_valid, out2_data
  );

  modport slave (
    input  in1_valid, in1_data, clear_overflow1,
    output in1_ready, overflow1, count1, out2_valid, out2_data
  );

endinterface

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer for a clock-domain crossing.
//   clock : destination-domain clock
//   reset : destination-domain reset, asynchronous, active-high
//   d     : bit arriving from the other domain
//   q     : synchronized copy after DEPTH flops
`timescale 1ns / 1ps
module sync_chain
  import bus_handshake_synchronizer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  // The attributes keep the stages as distinct flops placed close together
  // so the first stage has a full period to resolve metastability.
  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic [DEPTH-1:0] stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/bus_handshake_synchronizer.sv
// Two-phase (toggle) request/acknowledge synchronizer carrying one data word
// at a time from the clock1 domain to the clock2 domain.
//   clock1, reset1 : source-domain clock and async active-high reset
//   clock2, reset2 : destination-domain clock and async active-high reset
//   bus            : slave side of bus_handshake_synchronizer_if
//                    (in1_* / clear_overflow1 in, in1_ready / overflow1 /
//                     count1 / out2_* out)
// Only hold1 crosses as a multi-bit value; it is frozen while the request
// toggle travels across, so the destination can sample it directly.
`timescale 1ns / 1ps
module bus_handshake_synchronizer
  import bus_handshake_synchronizer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_DEPTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clock1,
  input  logic                           reset1,
  input  logic                           clock2,
  input  logic                           reset2,
  bus_handshake_synchronizer_if.slave    bus
);

  // Out-of-range depths are pulled back into the legal window rather than
  // building an unusable chain.
  localparam int DEPTH = (SYNC_DEPTH < SYNC_DEPTH_MIN) ? SYNC_DEPTH_MIN :
                         (SYNC_DEPTH > SYNC_DEPTH_MAX) ? SYNC_DEPTH_MAX :
                         SYNC_DEPTH;

  // Source (clock1) domain
  src_state_t             state;
  logic                   req1;
  logic [WIDTH-1:0]       hold1;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;
  logic                   ack_sync1;
  logic                   ack_prev1;
  logic                   ack_edge1;
  logic                   drop1;

  // Destination (clock2) domain
  logic                   req_sync2;
  logic                   req_prev2;
  logic                   req_edge2;
  logic                   ack2;
  logic                   valid2;
  logic [WIDTH-1:0]       data2;

  sync_chain #(.DEPTH(DEPTH)) u_req_sync (
    .clock (clock2),
    .reset (reset2),
    .d     (req1),
    .q     (req_sync2)
  );

  sync_chain #(.DEPTH(DEPTH)) u_ack_sync (
    .clock (clock1),
    .reset (reset1),
    .d     (ack2),
    .q     (ack_sync1)
  );

  assign ack_edge1 = ack_sync1 ^ ack_prev1;
  assign req_edge2 = req_sync2 ^ req_prev2;
  assign drop1     = (state == WAIT_ACK) && bus.in1_valid;

  // Source FSM: accept a word in IDLE, then wait for the acknowledge toggle.
  // An ack edge arriving in IDLE (only possible after a lone reset) is ignored.
  always_ff @(posedge clock1 or posedge reset1) begin
    if (reset1) begin
      state     <= IDLE;
      req1      <= 1'b0;
      hold1     <= '0;
      count     <= '0;
      ack_prev1 <= 1'b0;
    end else begin
      ack_prev1 <= ack_sync1;
      case (state)
        IDLE: begin
          if (bus.in1_valid) begin
            hold1 <= bus.in1_data;
            req1  <= ~req1;
            count <= count + COUNT_WIDTH'(1);
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_edge1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clock1 or posedge reset1) begin
    if (reset1) begin
      overflow <= 1'b0;
    end else if (drop1) begin
      overflow <= 1'b1;
    end else if (bus.clear_overflow1) begin
      overflow <= 1'b0;
    end
  end

  // Destination: each request edge loads the held word, pulses valid and
  // returns the acknowledge toggle on the same clock2 edge.
  always_ff @(posedge clock2 or posedge reset2) begin
    if (reset2) begin
      req_prev2 <= 1'b0;
      valid2    <= 1'b0;
      data2     <= '0;
      ack2      <= 1'b0;
    end else begin
      req_prev2 <= req_sync2;
      valid2    <= req_edge2;
      if (req_edge2) begin
        data2 <= hold1;
        ack2  <= ~ack2;
      end
    end
  end

  assign bus.in1_ready  = (state == IDLE);
  assign bus.overflow1  = overflow;
  assign bus.count1     = count;
  assign bus.out2_valid = valid2;
  assign bus.out2_data  = data2;

endmodule

// File: tb/tb_bus_handshake_synchronizer.sv
// Testbench for bus_handshake_synchronizer.
// Two DUTs share the clocks and resets: dut_a (WIDTH 8, SYNC_DEPTH 2,
// COUNT_WIDTH 16) and dut_b (WIDTH 32, SYNC_DEPTH 4, COUNT_WIDTH 4).
// Accepted words are queued when driven and checked as out2_valid pulses.
// The suite runs with clock1/clock2 = 8/18 ns and then 18/8 ns.
`timescale 1ns / 1ps
module tb_bus_handshake_synchronizer;

  logic clock1 = 1'b0;
  logic clock2 = 1'b0;
  logic reset1 = 1'b1;
  logic reset2 = 1'b1;
  int   half1  = 4;
  int   half2  = 9;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  exp_a[$];
  logic [31:0] exp_b[$];
  int pulses_a = 0;
  int pulses_b = 0;
  int edges2   = 0;
  int start_a  = 0;
  int start_b  = 0;
  int lat_a    = 0;
  int lat_b    = 0;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] count;
  } vec_t;
  vec_t vecs[4];

  always begin
    #(half1);
    clock1 = ~clock1;
  end

  always begin
    #(half2);
    clock2 = ~clock2;
  end

  bus_handshake_synchronizer_if #(.WIDTH(8),  .COUNT_WIDTH(16)) bus_a ();
  bus_handshake_synchronizer_if #(.WIDTH(32), .COUNT_WIDTH(4))  bus_b ();

  bus_handshake_synchronizer #(.WIDTH(8), .SYNC_DEPTH(2), .COUNT_WIDTH(16)) dut_a (
    .clock1 (clock1),
    .reset1 (reset1),
    .clock2 (clock2),
    .reset2 (reset2),
    .bus    (bus_a)
  );

  bus_handshake_synchronizer #(.WIDTH(32), .SYNC_DEPTH(4), .COUNT_WIDTH(4)) dut_b (
    .clock1 (clock1),
    .reset1 (reset1),
    .clock2 (clock2),
    .reset2 (reset2),
    .bus    (bus_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Destination-side monitor: every pulse must match the oldest queued word.
  always begin
    @(posedge clock2);
    edges2++;
    #1;
    if (bus_a.out2_valid) begin
      pulses_a++;
      lat_a = edges2 - start_a;
      if (exp_a.size() == 0) timeoutFail("unexpected_pulse_a");
      else checkOutput("data_a", bus_a.out2_data, exp_a.pop_front());
    end
    if (bus_b.out2_valid) begin
      pulses_b++;
      lat_b = edges2 - start_b;
      if (exp_b.size() == 0) timeoutFail("unexpected_pulse_b");
      else checkOutput("data_b", bus_b.out2_data, exp_b.pop_front());
    end
  end

  task automatic idleInputs();
    bus_a.in1_valid       = 1'b0;
    bus_a.in1_data        = '0;
    bus_a.clear_overflow1 = 1'b0;
    bus_b.in1_valid       = 1'b0;
    bus_b.in1_data        = '0;
    bus_b.clear_overflow1 = 1'b0;
  endtask

  task automatic doReset();
    reset1 = 1'b1;
    reset2 = 1'b1;
    idleInputs();
    repeat (3) @(negedge clock1);
    repeat (3) @(negedge clock2);
    exp_a.delete();
    exp_b.delete();
    pulses_a = 0;
    pulses_b = 0;
    @(negedge clock1);
    reset1 = 1'b0;
    reset2 = 1'b0;
  endtask

  task automatic waitReady(input bit use_a, input bit use_b, output bit ok);
    int guard = 0;
    @(negedge clock1);
    while (((use_a && !bus_a.in1_ready) || (use_b && !bus_b.in1_ready)) && guard < 500) begin
      @(negedge clock1);
      guard++;
    end
    ok = (guard < 500);
    if (!ok) timeoutFail("wait_ready");
  endtask

  // Offer one word for a single clock1 cycle on the selected DUT(s);
  // returns on the negedge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] data, input bit use_a, input bit use_b);
    bit ok;
    waitReady(use_a, use_b, ok);
    if (ok) begin
      if (use_a) begin
        bus_a.in1_valid = 1'b1;
        bus_a.in1_data  = data[7:0];
        exp_a.push_back(data[7:0]);
      end
      if (use_b) begin
        bus_b.in1_valid = 1'b1;
        bus_b.in1_data  = data;
        exp_b.push_back(data);
      end
      @(posedge clock1);
      #1;
      start_a = edges2;
      start_b = edges2;
      @(negedge clock1);
      bus_a.in1_valid = 1'b0;
      bus_b.in1_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int guard = 0;
    @(negedge clock1);
    while ((!bus_a.in1_ready || !bus_b.in1_ready || exp_a.size() != 0 || exp_b.size() != 0)
           && guard < 500) begin
      @(negedge clock1);
      guard++;
    end
    if (guard >= 500) timeoutFail("wait_idle");
  endtask

  task automatic testTable();
    doReset();
    checkOutput("rst_ready", bus_a.in1_ready, 1);
    checkOutput("rst_overflow", bus_a.overflow1, 0);
    checkOutput("rst_count", bus_a.count1, 0);
    checkOutput("rst_valid", bus_a.out2_valid, 0);
    checkOutput("rst_data", bus_a.out2_data, 0);
    checkOutput("rst_count_b", bus_b.count1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus({24'h0, vecs[i].data}, 1'b1, 1'b0);
      waitIdle();
      checkOutput("tbl_data", bus_a.out2_data, vecs[i].data);
      checkOutput("tbl_count", bus_a.count1, vecs[i].count);
      checkOutput("tbl_ready", bus_a.in1_ready, 1);
      checkOutput("tbl_overflow", bus_a.overflow1, 0);
      if (i == 0) checkOutput("tbl_latency_window", (lat_a >= 2 && lat_a <= 4), 1);
    end
    checkOutput("tbl_pulses", pulses_a, 4);
  endtask

  task automatic testBackToBack();
    int sent  = 0;
    int guard = 0;
    doReset();
    while (sent < 16 && guard < 2000) begin
      @(negedge clock1);
      guard++;
      if (bus_a.in1_ready) begin
        bus_a.in1_valid = 1'b1;
        bus_a.in1_data  = 8'(sent + 1);
        exp_a.push_back(8'(sent + 1));
        sent++;
      end else begin
        bus_a.in1_valid = 1'b0;
      end
    end
    @(negedge clock1);
    bus_a.in1_valid = 1'b0;
    if (guard >= 2000) timeoutFail("b2b_send");
    waitIdle();
    checkOutput("b2b_count", bus_a.count1, 16);
    checkOutput("b2b_pulses", pulses_a, 16);
    checkOutput("b2b_last_data", bus_a.out2_data, 8'h10);
    checkOutput("b2b_overflow", bus_a.overflow1, 0);
  endtask

  task automatic testOverrun();
    bit ok;
    waitReady(1'b1, 1'b0, ok);
    bus_a.in1_valid = 1'b1;
    bus_a.in1_data  = 8'h11;
    exp_a.push_back(8'h11);
    @(negedge clock1);
    checkOutput("ovr_busy1", bus_a.in1_ready, 0);
    bus_a.in1_data = 8'h22;
    @(negedge clock1);
    checkOutput("ovr_busy2", bus_a.in1_ready, 0);
    bus_a.in1_data = 8'h33;
    @(negedge clock1);
    bus_a.in1_valid = 1'b0;
    waitIdle();
    checkOutput("ovr_flag", bus_a.overflow1, 1);
    checkOutput("ovr_data", bus_a.out2_data, 8'h11);
    checkOutput("ovr_count", bus_a.count1, 17);
    // clear alone
    @(negedge clock1);
    bus_a.clear_overflow1 = 1'b1;
    @(negedge clock1);
    bus_a.clear_overflow1 = 1'b0;
    checkOutput("ovr_clear", bus_a.overflow1, 0);
    // set and clear in the same cycle
    waitReady(1'b1, 1'b0, ok);
    bus_a.in1_valid = 1'b1;
    bus_a.in1_data  = 8'h55;
    exp_a.push_back(8'h55);
    @(negedge clock1);
    checkOutput("ovr_busy3", bus_a.in1_ready, 0);
    bus_a.in1_data        = 8'h66;
    bus_a.clear_overflow1 = 1'b1;
    @(negedge clock1);
    bus_a.in1_valid       = 1'b0;
    bus_a.clear_overflow1 = 1'b0;
    checkOutput("ovr_set_wins", bus_a.overflow1, 1);
    waitIdle();
    checkOutput("ovr_data2", bus_a.out2_data, 8'h55);
    @(negedge clock1);
    bus_a.clear_overflow1 = 1'b1;
    @(negedge clock1);
    bus_a.clear_overflow1 = 1'b0;
    checkOutput("ovr_clear2", bus_a.overflow1, 0);
  endtask

  task automatic testJointReset();
    applyStimulus(32'h77, 1'b1, 1'b0);
    checkOutput("jr_busy", bus_a.in1_ready, 0);
    doReset();
    checkOutput("jr_ready", bus_a.in1_ready, 1);
    checkOutput("jr_data", bus_a.out2_data, 0);
    checkOutput("jr_count", bus_a.count1, 0);
    repeat (20) @(negedge clock1);
    checkOutput("jr_no_pulse", pulses_a, 0);
    applyStimulus(32'h99, 1'b1, 1'b0);
    waitIdle();
    checkOutput("jr_after_data", bus_a.out2_data, 8'h99);
    checkOutput("jr_after_pulses", pulses_a, 1);
  endtask

  task automatic testDepth();
    doReset();
    applyStimulus(32'hDEADBEEF, 1'b1, 1'b1);
    waitIdle();
    checkOutput("depth_data_b", bus_b.out2_data, 32'hDEADBEEF);
    checkOutput("depth_data_a", bus_a.out2_data, 8'hEF);
    checkOutput("depth_lat_a_window", (lat_a >= 2 && lat_a <= 4), 1);
    checkOutput("depth_lat_delta", 64'(lat_b - lat_a), 2);
  endtask

  task automatic testWrap();
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(32'h1000_0000 + 32'(i), 1'b0, 1'b1);
      waitIdle();
    end
    checkOutput("wrap_count", bus_b.count1, 1);
    checkOutput("wrap_pulses", pulses_b, 17);
  endtask

  task automatic runSuite(input int h1, input int h2);
    half1 = h1;
    half2 = h2;
    $display("[TB] clock1 half period %0d ns, clock2 half period %0d ns", h1, h2);
    testTable();
    testBackToBack();
    testOverrun();
    testJointReset();
    testDepth();
    testWrap();
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, count: 16'd1};
    vecs[1] = '{data: 8'h00, count: 16'd2};
    vecs[2] = '{data: 8'hFF, count: 16'd3};
    vecs[3] = '{data: 8'h3C, count: 16'd4};
    idleInputs();
    runSuite(4, 9);
    runSuite(9, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
